// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush controller for the 5-stage RV32 pipeline: per-stage STALL/CLEAR decisions.
// Optional macro HAZARD_PERF_COUNTERS_EN adds the stall-cycle and flush-event counters.
module pipeline_hazard_ctrl #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 256,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    input  logic                 use_rs1_d,
    input  logic                 use_rs2_d,
    input  logic [4:0]           rd_e,
    input  logic                 mem_read_e,
    input  logic                 branch_taken_e,
    input  logic                 imem_ready,
    input  logic                 dmem_req_m,
    input  logic                 dmem_ready,
    output logic                 STALL_F,
    output logic                 STALL_D,
    output logic                 STALL_E,
    output logic                 STALL_M,
    output logic                 CLEAR_D,
    output logic                 CLEAR_E,
    output logic                 CLEAR_M,
    output logic                 CLEAR_W,
    output logic                 mem_timeout_err,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_HOLD  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [15:0] WD_MAX  = 16'(MEM_TIMEOUT);
    localparam logic [1:0]  LU_INIT = 2'(LOAD_USE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  lu_cnt_q, lu_cnt_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        err_q, err_d;

    logic load_use;
    logic dmem_wait;
    logic hold_pc, hold_ifid, hold_idex, hold_exmem;
    logic bub_ifid, bub_idex, bub_memwb;

    assign load_use = mem_read_e & (rd_e != 5'd0) &
                      ((use_rs1_d & (rs1_d == rd_e)) | (use_rs2_d & (rs2_d == rd_e)));

    assign dmem_wait = ~dmem_ready & (dmem_req_m | (state_q == MEM_WAIT));

    always_comb begin
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        err_d      = err_q;
        hold_pc    = 1'b0;
        hold_ifid  = 1'b0;
        hold_idex  = 1'b0;
        hold_exmem = 1'b0;
        bub_ifid   = 1'b0;
        bub_idex   = 1'b0;
        bub_memwb  = 1'b0;

        if (dmem_wait) begin
            // Whole front end frozen; EX-stage redirects and load-use are re-evaluated on release.
            hold_pc    = 1'b1;
            hold_ifid  = 1'b1;
            hold_idex  = 1'b1;
            hold_exmem = 1'b1;
            bub_memwb  = 1'b1;
            state_d    = MEM_WAIT;
            lu_cnt_d   = 2'd0;
            if (wd_cnt_q != WD_MAX) begin
                wd_cnt_d = wd_cnt_q + 16'd1;
            end
            if (wd_cnt_d == WD_MAX) begin
                err_d = 1'b1;
            end
        end else begin
            state_d  = RUN;
            wd_cnt_d = 16'd0;
            if (branch_taken_e) begin
                bub_ifid = 1'b1;
                bub_idex = 1'b1;
                lu_cnt_d = 2'd0;
            end else if (state_q == LU_HOLD) begin
                hold_pc   = 1'b1;
                hold_ifid = 1'b1;
                bub_idex  = 1'b1;
                lu_cnt_d  = lu_cnt_q - 2'd1;
                state_d   = (lu_cnt_d == 2'd0) ? RUN : LU_HOLD;
            end else if (load_use) begin
                hold_pc   = 1'b1;
                hold_ifid = 1'b1;
                bub_idex  = 1'b1;
                if (LOAD_USE_CYCLES > 1) begin
                    state_d  = LU_HOLD;
                    lu_cnt_d = LU_INIT;
                end
            end else if (!imem_ready) begin
                hold_pc  = 1'b1;
                bub_ifid = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= RUN;
            lu_cnt_q <= 2'd0;
            wd_cnt_q <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    // Reset forces every pipeline register to a bubble.
    assign STALL_F = RST & hold_pc;
    assign STALL_D = RST & hold_ifid;
    assign STALL_E = RST & hold_idex;
    assign STALL_M = RST & hold_exmem;
    assign CLEAR_D = ~RST | bub_ifid;
    assign CLEAR_E = ~RST | bub_idex;
    assign CLEAR_M = ~RST;
    assign CLEAR_W = ~RST | bub_memwb;

    assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
    logic                 stall_any, flush_hit;

    assign stall_any = hold_pc | hold_ifid | hold_idex | hold_exmem;
    assign flush_hit = branch_taken_e & ~dmem_wait;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_any) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
            if (flush_hit) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
